// File: rtl/ex_mdu_ctrl_pkg.sv
// ex_mdu_ctrl_pkg: shared constants and types for the RV32M multi-cycle sequencer.
// Holds the M-extension func7/func3 encodings, FSM state encoding, datapath
// step mode and operand-signedness helpers used by the controller and its bench.
package ex_mdu_ctrl_pkg;

  localparam int unsigned FUNC3_W    = 3;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [6:0] INST_FUNC7_M = 7'b0000001;

  localparam logic [FUNC3_W-1:0] INST_MUL    = 3'b000;
  localparam logic [FUNC3_W-1:0] INST_MULH   = 3'b001;
  localparam logic [FUNC3_W-1:0] INST_MULHSU = 3'b010;
  localparam logic [FUNC3_W-1:0] INST_MULHU  = 3'b011;
  localparam logic [FUNC3_W-1:0] INST_DIV    = 3'b100;
  localparam logic [FUNC3_W-1:0] INST_DIVU   = 3'b101;
  localparam logic [FUNC3_W-1:0] INST_REM    = 3'b110;
  localparam logic [FUNC3_W-1:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

  // rs1 is interpreted as signed by these functions
  function automatic logic op1_signed(input logic [FUNC3_W-1:0] f3);
    return (f3 == INST_MULH) || (f3 == INST_MULHSU) || (f3 == INST_DIV) || (f3 == INST_REM);
  endfunction

  // rs2 is interpreted as signed by these functions
  function automatic logic op2_signed(input logic [FUNC3_W-1:0] f3);
    return (f3 == INST_MULH) || (f3 == INST_DIV) || (f3 == INST_REM);
  endfunction

endpackage

// File: rtl/ex_mdu_ctrl_if.sv
// ex_mdu_ctrl_if: execute-stage <-> M-extension sequencer handshake.
// master (execute stage): drives start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i;
//                         observes stall_o, rd_data_o, rd_addr_o, rd_wen_o.
// slave  (sequencer):     the mirror image.
interface ex_mdu_ctrl_if
  import ex_mdu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic                  start_i;
  logic [FUNC3_W-1:0]    func3_i;
  logic [XLEN-1:0]       op1_i;
  logic [XLEN-1:0]       op2_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  flush_i;
  logic                  stall_o;
  logic [XLEN-1:0]       rd_data_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic                  rd_wen_o;

  modport master (
    output start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  stall_o, rd_data_o, rd_addr_o, rd_wen_o
  );

  modport slave (
    input  start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
    output stall_o, rd_data_o, rd_addr_o, rd_wen_o
  );

endinterface

// File: rtl/ex_mdu_ctrl_step.sv
// ex_mdu_ctrl_step: one iteration of the shared shift/add datapath.
// mode=STEP_MUL: shift-add multiply; acc:lo is the running product, lo[0] the
//                current multiplier bit, b the multiplicand.
// mode=STEP_DIV: restoring divide; acc is the partial remainder, lo the
//                dividend shifting out / quotient shifting in, b the divisor.
// Ports: mode, acc, lo, b in; acc_next, lo_next out (purely combinational).
module ex_mdu_ctrl_step
  import ex_mdu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  step_mode_t      mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (lo[0] ? {1'b0, b} : '0);
    shifted  = {acc, lo[XLEN-1]};
    diff     = shifted - {1'b0, b};
    acc_next = acc;
    lo_next  = lo;
    if (mode == STEP_MUL) begin
      // carry of the add becomes the new top bit of the product
      acc_next = sum[XLEN:1];
      lo_next  = {sum[0], lo[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      // no borrow: divisor fits, keep the difference and shift in a 1
      acc_next = diff[XLEN-1:0];
      lo_next  = {lo[XLEN-2:0], 1'b1};
    end else begin
      acc_next = shifted[XLEN-1:0];
      lo_next  = {lo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_mdu_ctrl.sv
// ex_mdu_ctrl: iterative RV32M sequencer (MUL*/DIV*/REM*), one bit per cycle.
// Ports: clk, rst (sync, active-high), bus (ex_mdu_ctrl_if.slave):
//   start_i/func3_i/op1_i/op2_i/rd_addr_i request, flush_i abort,
//   stall_o pipeline hold, rd_data_o/rd_addr_o/rd_wen_o one-cycle writeback.
module ex_mdu_ctrl
  import ex_mdu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_mdu_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FUNC3_W-1:0]    func3_q, func3_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       acc_q, acc_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0]       fast_res_q, fast_res_d;
  logic                  neg_q, neg_d, fast_q, fast_d;

  step_mode_t            step_mode;
  logic [XLEN-1:0]       step_acc, step_lo;
  logic                  sign1, sign2, div_zero, div_ovf, wen;
  logic [XLEN-1:0]       mag1, mag2;
  logic [PW-1:0]         prod, prod_fix;
  logic [XLEN-1:0]       mul_res, div_raw, div_fix, result;

  // Operand decode for the request currently presented
  assign sign1    = op1_signed(bus.func3_i) & bus.op1_i[XLEN-1];
  assign sign2    = op2_signed(bus.func3_i) & bus.op2_i[XLEN-1];
  assign mag1     = sign1 ? (~bus.op1_i + XLEN'(1)) : bus.op1_i;
  assign mag2     = sign2 ? (~bus.op2_i + XLEN'(1)) : bus.op2_i;
  assign div_zero = (bus.op2_i == '0);
  assign div_ovf  = ((bus.func3_i == INST_DIV) || (bus.func3_i == INST_REM)) &&
                    (bus.op1_i == INT_MIN) && (bus.op2_i == '1);

  assign step_mode = (state_q == ST_DIV) ? STEP_DIV : STEP_MUL;

  ex_mdu_ctrl_step #(.XLEN(XLEN)) u_step (
    .mode     (step_mode),
    .acc      (acc_q),
    .lo       (lo_q),
    .b        (b_q),
    .acc_next (step_acc),
    .lo_next  (step_lo)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      func3_q    <= '0;
      rd_addr_q  <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      fast_res_q <= '0;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      func3_q    <= func3_d;
      rd_addr_q  <= rd_addr_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      fast_res_q <= fast_res_d;
      neg_q      <= neg_d;
      fast_q     <= fast_d;
    end
  end

  // Next-state and writeback strobe
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    func3_d    = func3_q;
    rd_addr_d  = rd_addr_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    b_d        = b_q;
    fast_res_d = fast_res_q;
    neg_d      = neg_q;
    fast_d     = fast_q;
    wen        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          func3_d   = bus.func3_i;
          rd_addr_d = bus.rd_addr_i;
          cnt_d     = '0;
          fast_d    = 1'b0;
          acc_d     = '0;
          if (bus.func3_i[2]) begin
            // dividend shifts out of lo into acc; quotient fills lo from the bottom
            lo_d  = mag1;
            b_d   = mag2;
            neg_d = bus.func3_i[1] ? sign1 : (sign1 ^ sign2);
            if (div_zero || div_ovf) begin
              fast_d     = 1'b1;
              fast_res_d = div_zero ? (bus.func3_i[1] ? bus.op1_i : '1)
                                    : (bus.func3_i[1] ? '0 : INT_MIN);
              state_d    = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end else begin
            lo_d    = mag2;
            b_d     = mag1;
            neg_d   = sign1 ^ sign2;
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        wen     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // abort wins over everything, including a pending writeback
    if (bus.flush_i) begin
      state_d = ST_IDLE;
      wen     = 1'b0;
    end
  end

  // Sign fix-up and word select, resolved within the DONE cycle
  assign prod     = {acc_q, lo_q};
  assign prod_fix = neg_q ? (~prod + PW'(1)) : prod;
  assign mul_res  = (func3_q == INST_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
  assign div_raw  = func3_q[1] ? acc_q : lo_q;
  assign div_fix  = neg_q ? (~div_raw + XLEN'(1)) : div_raw;
  assign result   = fast_q ? fast_res_q : (func3_q[2] ? div_fix : mul_res);

  assign bus.stall_o   = ((state_q == ST_IDLE) && bus.start_i) ||
                         (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.rd_wen_o  = wen;
  assign bus.rd_data_o = wen ? result : '0;
  assign bus.rd_addr_o = wen ? rd_addr_q : '0;

endmodule

// File: doc/ex_mdu_ctrl.md
# ex_mdu_ctrl

Multi-cycle RV32M sequencer for the execute stage of the three-stage pipeline. The execute stage hands it MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations. It runs them iteratively, one bit per cycle, and holds the pipeline stalled until the result is written back. It owns the shared shift/add datapath, so only one M-extension operation is in flight at a time.

## Interface
Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- start_i  in  1  execute stage presents an M-extension op (opcode INST_TYPE_R_M, func7 0000001)
- func3_i  in  3  M-extension function select
- op1_i  in  XLEN  rs1 value (dividend / multiplicand)
- op2_i  in  XLEN  rs2 value (divisor / multiplier)
- rd_addr_i  in  5  destination register
- flush_i  in  1  abort in-flight op (branch/jump redirect)
- stall_o  out  1  hold IF/ID and ID/EX registers
- rd_data_o  out  XLEN  result
- rd_addr_o  out  5  destination register
- rd_wen_o  out  1  one-cycle write-enable pulse

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1, flush_i=0:
  - Latch func3, rd_addr and the operand magnitudes.
  - Latch the result-sign flags:
    - MULH: sign1^sign2.
    - MULHSU: sign1.
    - DIV: sign1^sign2, if divisor≠0.
    - REM: sign1.
  - Clear the 5-bit iteration counter.
  - Next state is MUL for func3 0xx and DIV for func3 1xx.
- Fast path, taken from IDLE directly to DONE (latency 1), result forced:
  - Divisor zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- MUL:
  - 64-bit shift-add, one multiplier bit per cycle, 32 cycles.
  - On counter==31 go to DONE.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle, 32 cycles.
  - On counter==31 go to DONE.
- DONE:
  - Apply sign fix-up by two's-complement negation of the 64-bit product or the quotient/remainder.
  - Select the low word for MUL and the high word for MULH/MULHSU/MULHU.
  - Drive rd_data_o, rd_addr_o and rd_wen_o=1 for exactly one cycle.
  - Next state IDLE.
- stall_o = (IDLE & start_i) | MUL | DIV. It is low in DONE, so the pipeline advances while the result writes back.
- start_i is ignored outside IDLE.
- flush_i in any state:
  - Next state IDLE.
  - No rd_wen_o pulse is produced; in DONE the pulse is suppressed that cycle.
  - flush_i has priority over start_i.
- rst:
  - Next state IDLE, counter 0.
  - Outputs rd_wen_o=0, rd_data_o=0, rd_addr_o=0, stall_o=0 (combinational: 0 when IDLE and start_i low).
- rd_data_o and rd_addr_o read 0 whenever rd_wen_o=0.

## Timing
- Start accepted at edge 0.
- Iterative ops: MUL/DIV occupy cycles 1–32, DONE at cycle 33, rd_wen_o high during cycle 33. The op stalls the pipeline for 33 cycles.
- Fast-path ops: DONE at cycle 1, one stall cycle.
- Back-to-back: a new start_i in the cycle after DONE (IDLE) is accepted normally.
- Result fix-up completes combinationally within the DONE cycle; no extra latency.

## Structure
- Add to defines.v:
  - INST_FUNC7_M = 7'b0000001.
  - INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU, INST_DIV, INST_DIVU, INST_REM, INST_REMU func3 codes.
  - FSM state encodings.
- One natural sub-module: mdu_step, the combinational single-iteration shift-add/compare-subtract unit selected by MUL/DIV mode.
- The ex module instantiates ex_mdu_ctrl and muxes its rd_* outputs into the writeback path when rd_wen_o=1.

## Test plan
- MUL 7 × 0xFFFFFFFD after reset → stall_o high cycles 0–32; rd_wen_o pulse at cycle 33, rd_data_o=0xFFFFFFEB, rd_addr_o echoed.
- 0xFFFFFFFF × 0xFFFFFFFF: MULHU → 0xFFFFFFFE; MULH → 0x00000000; MULHSU → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with rd_wen_o at cycle 1; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- Abort: flush_i at cycle 10 of a DIV → IDLE at cycle 11, no rd_wen_o, stall_o low. Repeat with rst at cycle 10 → same. A start_i at cycle 12 completes normally at cycle 45.
- Back-to-back: MUL then DIV issued in the cycle after DONE → two separate pulses at cycles 33 and 67; start_i held during MUL is ignored.
